// File: rtl/regfile_pkg.sv
// Shared widths and types for the 16 x 16-bit general-purpose register file.
// Also holds the read-port select helper that the top uses for both ports.
package regfile_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

  // In-flight write data wins over the stored value; reset forces zero.
  function automatic reg_data_t read_sel(
    input logic      rst_n,
    input logic      byp_hit,
    input reg_data_t wr_data,
    input reg_data_t stored
  );
    reg_data_t res;
    res = '0;
    if (rst_n) begin
      res = byp_hit ? wr_data : stored;
    end
    return res;
  endfunction

endpackage

// File: rtl/gpr_register.sv
// One register-file entry: loads wr_data_i on clk when wr_en_i, cleared while rst_n is low.
// Single-cycle write latency; the output is the stored value with no backpressure.
module gpr_register
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  reg_data_t data_d;
  reg_data_t data_q;

  always_comb begin
    data_d = data_q;
    if (wr_en_i) begin
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/register_file.sv
// 16 x 16-bit register file: two combinational read ports with write bypass, one write port.
// Reads are zero-latency, writes commit on the rising edge; never stalls.
module register_file
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] SrcReg1,
  input  logic [REG_IDX_W-1:0] SrcReg2,
  input  logic [REG_IDX_W-1:0] DstReg,
  input  logic                 WriteReg,
  input  logic [DATA_W-1:0]    DstData,
  output logic [DATA_W-1:0]    SrcData1,
  output logic [DATA_W-1:0]    SrcData2
);

  logic [NUM_REGS-1:0] wr_en;
  reg_data_t           rf_q [NUM_REGS];
  logic                byp1_hit;
  logic                byp2_hit;

  // One-hot write decode; R0 is ordinary storage like every other entry.
  always_comb begin
    wr_en = '0;
    if (WriteReg) begin
      wr_en[DstReg] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_gpr
    gpr_register u_gpr (
      .clk       (clk),
      .rst_n     (rst),
      .wr_en_i   (wr_en[i]),
      .wr_data_i (DstData),
      .rd_data_o (rf_q[i])
    );
  end

  assign byp1_hit = WriteReg && (DstReg == SrcReg1);
  assign byp2_hit = WriteReg && (DstReg == SrcReg2);

  always_comb begin
    SrcData1 = read_sel(rst, byp1_hit, DstData, rf_q[SrcReg1]);
    SrcData2 = read_sel(rst, byp2_hit, DstData, rf_q[SrcReg2]);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, enable gating, bypass, sweep, async reset.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;

  int n_checks = 0;
  int n_fails  = 0;

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [15:0] data);
    @(negedge clk);
    DstReg   = idx;
    DstData  = data;
    WriteReg = 1'b1;
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
  endtask

  task automatic read_pair(input logic [3:0] a, input logic [3:0] b);
    SrcReg1 = a;
    SrcReg2 = b;
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    SrcReg1  = '0;
    SrcReg2  = '0;
    DstReg   = '0;
    WriteReg = 1'b0;
    DstData  = '0;

    // Reset held: every index reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      read_pair(4'(n), 4'(15 - n));
      check_eq($sformatf("reset_p1_r%0d", n), SrcData1, 16'h0000);
      check_eq($sformatf("reset_p2_r%0d", 15 - n), SrcData2, 16'h0000);
    end
    // Bypass must stay off while reset is low.
    DstReg = 4'd3; DstData = 16'hFFFF; WriteReg = 1'b1;
    read_pair(4'd3, 4'd3);
    check_eq("reset_bypass_p1", SrcData1, 16'h0000);
    check_eq("reset_bypass_p2", SrcData2, 16'h0000);
    WriteReg = 1'b0;

    @(negedge clk);
    rst = 1'b1;

    // Basic write then read, including R0.
    write_reg(4'd0, 16'hABCD);
    write_reg(4'd1, 16'hBFF0);
    read_pair(4'd0, 4'd1);
    check_eq("basic_r0", SrcData1, 16'hABCD);
    check_eq("basic_r1", SrcData2, 16'hBFF0);

    // Write enable gating.
    write_reg(4'd2, 16'h1111);
    @(negedge clk);
    DstReg = 4'd2; DstData = 16'hFFFF; WriteReg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_pair(4'd2, 4'd2);
    check_eq("gate_r2_p1", SrcData1, 16'h1111);
    check_eq("gate_r2_p2", SrcData2, 16'h1111);

    // Bypass on both ports, then independently per port.
    @(negedge clk);
    read_pair(4'd5, 4'd5);
    check_eq("byp_pre_r5", SrcData1, 16'h0000);
    DstReg = 4'd5; DstData = 16'h1234; WriteReg = 1'b1;
    #1;
    check_eq("byp_p1", SrcData1, 16'h1234);
    check_eq("byp_p2", SrcData2, 16'h1234);
    read_pair(4'd5, 4'd0);
    check_eq("byp_only_p1", SrcData1, 16'h1234);
    check_eq("byp_p2_r0", SrcData2, 16'hABCD);
    read_pair(4'd1, 4'd5);
    check_eq("byp_p1_r1", SrcData1, 16'hBFF0);
    check_eq("byp_only_p2", SrcData2, 16'h1234);
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
    read_pair(4'd5, 4'd5);
    check_eq("byp_post_p1", SrcData1, 16'h1234);
    check_eq("byp_post_p2", SrcData2, 16'h1234);

    // Full sweep with distinct per-index values.
    for (int n = 0; n < 16; n++) begin
      write_reg(4'(n), 16'hA500 | 16'(n));
    end
    for (int n = 0; n < 16; n++) begin
      read_pair(4'(n), 4'(15 - n));
      check_eq($sformatf("sweep_p1_r%0d", n), SrcData1, 16'hA500 | 16'(n));
      check_eq($sformatf("sweep_p2_r%0d", 15 - n), SrcData2, 16'hA500 | 16'(15 - n));
    end

    // Async reset between edges: outputs drop with no clock.
    @(negedge clk);
    read_pair(4'd3, 4'd12);
    check_eq("pre_arst_r3", SrcData1, 16'hA503);
    rst = 1'b0;
    #1;
    check_eq("arst_r3", SrcData1, 16'h0000);
    check_eq("arst_r12", SrcData2, 16'h0000);
    // Write attempted during reset is ignored.
    DstReg = 4'd7; DstData = 16'hBEEF; WriteReg = 1'b1;
    read_pair(4'd7, 4'd7);
    check_eq("arst_byp_r7", SrcData1, 16'h0000);
    @(posedge clk);
    #1;
    WriteReg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    read_pair(4'd7, 4'd15);
    check_eq("post_arst_r7", SrcData1, 16'h0000);
    check_eq("post_arst_r15", SrcData2, 16'h0000);
    write_reg(4'd7, 16'hBEEF);
    read_pair(4'd7, 4'd6);
    check_eq("post_arst_wr_r7", SrcData1, 16'hBEEF);
    check_eq("post_arst_r6", SrcData2, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry x 16-bit general-purpose register file for the processor datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between decode (source/destination register specifiers) and execute/writeback (write data).
- Write-to-read bypass is provided so a register written in a cycle is visible to readers in that same cycle.

Parameters:
- DATA_W, 16, width of each register and of all data ports
- NUM_REGS, 16, number of registers; index width is log2(NUM_REGS) = 4

Ports:
- clk  input  1  single clock; all state updates occur on the rising edge
- rst  input  1  asynchronous reset, active-low; clears every register while low
- SrcReg1  input  4  read port 1 register index
- SrcReg2  input  4  read port 2 register index
- DstReg  input  4  write port register index
- WriteReg  input  1  write enable, active-high
- DstData  input  16  write data
- SrcData1  output  16  read port 1 data
- SrcData2  output  16  read port 2 data

Behaviour:
- Reset: rst low asynchronously forces all 16 registers to 16'h0000, independent of clk.
  - Outputs follow combinationally, so both ports read 0 for any index during reset.
  - Bypass is disabled during reset: outputs are 0 even if WriteReg=1.
  - Deassertion takes effect asynchronously; the first write can occur on the next rising edge with rst high.
- Write: on posedge clk with rst high and WriteReg=1, reg[DstReg] <= DstData.
  - WriteReg=0 leaves all registers unchanged.
  - Exactly one register is written per edge.
- All 16 registers are ordinary storage. R0 is NOT hardwired to zero; it is readable and writable like any other register.
- Read: SrcDataN = reg[SrcRegN], purely combinational with zero-cycle latency. The output changes in the same delta as the index or stored value changes.
- Bypass: if WriteReg=1 and DstReg==SrcRegN (rst high), then SrcDataN = DstData combinationally, before the edge commits the write.
  - Applies independently to each port.
  - Both ports may bypass simultaneously.
- Both ports may address the same register; both then return identical data.
- No X propagation from stored state after reset: every register has a defined reset value.
- All index values 0..15 are valid; there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W, NUM_REGS, REG_IDX_W constants
  - typedef reg_idx_t (logic [3:0])
  - typedef reg_data_t (logic [15:0])
- One natural sub-module: gpr_register.
  - A single 16-bit register with write enable and asynchronous active-low clear.
  - Instantiated 16 times via generate.
- The 4-to-16 write decoder and the two 16:1 read muxes with bypass compare live in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles, sweep SrcReg1/SrcReg2 over 0..15 -> every read is 16'h0000.
- Basic write/read: write R0=16'hABCD, then R1=16'hBFF0; set SrcReg1=0, SrcReg2=1 -> SrcData1=ABCD, SrcData2=BFF0 after the writes commit.
- Write enable gating: with R2=16'h1111, drive DstReg=2, DstData=16'hFFFF, WriteReg=0 for 3 edges -> R2 still reads 1111.
- Bypass: R5 holds 16'h0000; set DstReg=5, DstData=16'h1234, WriteReg=1, SrcReg1=SrcReg2=5 -> both outputs read 1234 before the edge; after the edge with WriteReg=0 they still read 1234.
- Full sweep: write Rn=16'hA500|n for n=0..15, read back all pairs (n, 15-n) -> exact values with no aliasing between indices.
- Async reset mid-operation: with all registers written nonzero, pull rst low between edges -> all outputs read 0000 immediately, no clock needed; a write attempted while rst is low is ignored.
